// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline opcodes and stall FSM state type
// Purpose: opcode constants (MIPS-style 6-bit encodings) and the load-use
//          stall FSM state enum, shared by the stall controller and decoder.
// Ports:   none (package)
package pipe_pkg;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_J     = 6'h02;
  localparam logic [5:0] OPCODE_JAL   = 6'h03;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_BNE   = 6'h05;
  // Immediate ALU set: reads rs only, rt is the destination.
  localparam logic [5:0] OPCODE_ADDI  = 6'h08;
  localparam logic [5:0] OPCODE_ADDIU = 6'h09;
  localparam logic [5:0] OPCODE_SLTI  = 6'h0A;
  localparam logic [5:0] OPCODE_SLTIU = 6'h0B;
  localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
  localparam logic [5:0] OPCODE_ORI   = 6'h0D;
  localparam logic [5:0] OPCODE_XORI  = 6'h0E;
  localparam logic [5:0] OPCODE_LUI   = 6'h0F;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2B;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } stall_state_e;

endpackage

// File: rtl/load_use_stall_ctrl_if.sv
// rtl/load_use_stall_ctrl_if.sv - ID/EX/MEM hazard bus for the load-use stall controller
// Purpose: bundles the pipeline-side inputs and stall/bubble outputs.
// Ports (signals): flush, id_valid, id_opcode, id_rs, id_rt, ex_valid,
//   ex_opcode, ex_dest, mem_ack (pipeline -> controller);
//   stall, bubble, stall_cnt, timeout_err (controller -> pipeline).
// Modports: master = pipeline side, slave = controller side.
interface load_use_stall_ctrl_if #(
  parameter int REG_AW   = 5,
  parameter int OPCODE_W = 6,
  parameter int CNT_W    = 16
);
  logic                flush;
  logic                id_valid;
  logic [OPCODE_W-1:0] id_opcode;
  logic [REG_AW-1:0]   id_rs;
  logic [REG_AW-1:0]   id_rt;
  logic                ex_valid;
  logic [OPCODE_W-1:0] ex_opcode;
  logic [REG_AW-1:0]   ex_dest;
  logic                mem_ack;
  logic                stall;
  logic                bubble;
  logic [CNT_W-1:0]    stall_cnt;
  logic                timeout_err;

  modport master (
    output flush, id_valid, id_opcode, id_rs, id_rt,
           ex_valid, ex_opcode, ex_dest, mem_ack,
    input  stall, bubble, stall_cnt, timeout_err
  );

  modport slave (
    input  flush, id_valid, id_opcode, id_rs, id_rt,
           ex_valid, ex_opcode, ex_dest, mem_ack,
    output stall, bubble, stall_cnt, timeout_err
  );
endinterface

// File: rtl/load_use_stall_ctrl_src_use_decode.sv
// rtl/load_use_stall_ctrl_src_use_decode.sv - decodes which source registers an ID opcode reads
// Purpose: module src_use_decode, purely combinational.
// Ports: opcode (in, OPCODE_W), use_rs (out), use_rt (out).
module src_use_decode
  import pipe_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic                use_rs,
  output logic                use_rt
);

  always_comb begin
    // Unlisted opcodes are assumed to read rs; rt is read only when the
    // instruction really compares/stores it, so immediates never false-stall.
    use_rs = !((opcode == OPCODE_W'(OPCODE_J))   ||
               (opcode == OPCODE_W'(OPCODE_JAL)) ||
               (opcode == OPCODE_W'(OPCODE_LUI)));
    use_rt = (opcode == OPCODE_W'(OPCODE_RTYPE)) ||
             (opcode == OPCODE_W'(OPCODE_BEQ))   ||
             (opcode == OPCODE_W'(OPCODE_BNE))   ||
             (opcode == OPCODE_W'(OPCODE_SW));
  end

endmodule

// File: rtl/load_use_stall_ctrl.sv
// rtl/load_use_stall_ctrl.sv - load-use hazard stall/bubble controller with variable-latency memory
// Purpose: detects a load in EX feeding a source the ID instruction reads,
//   freezes PC/IF-ID and bubbles ID/EX until mem_ack returns the load data.
//   Keeps a saturating stall-cycle counter; flush cancels the stall.
// Ports: clk, rst_n (async active-low), bus (load_use_stall_ctrl_if.slave).
// Option: LOAD_TIMEOUT_EN - bounds WAIT_MEM to TIMEOUT_CYC cycles and pulses
//   timeout_err on expiry; undefined = wait indefinitely, timeout_err tied 0.
module load_use_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int OPCODE_W    = 6,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  load_use_stall_ctrl_if.slave bus
);

  stall_state_e      state;
  logic              use_rs;
  logic              use_rt;
  logic              hazard;
  logic              stall_c;
  logic [REG_AW-1:0] ex_dest;
  logic [CNT_W-1:0]  stall_cnt_q;

  assign ex_dest = bus.ex_dest;

  src_use_decode #(.OPCODE_W(OPCODE_W)) u_src_use_decode (
    .opcode (bus.id_opcode),
    .use_rs (use_rs),
    .use_rt (use_rt)
  );

  assign hazard = bus.id_valid && bus.ex_valid &&
                  (bus.ex_opcode == OPCODE_W'(OPCODE_LW)) &&
                  (ex_dest != '0) &&
                  ((use_rs && (bus.id_rs == ex_dest)) ||
                   (use_rt && (bus.id_rt == ex_dest)));

  // Gated by rst_n so asserting reset mid-stall releases the pipeline
  // without waiting for the state register to be observed.
  always_comb begin
    stall_c = 1'b0;
    if (rst_n && !bus.flush) begin
      stall_c = (state == ST_IDLE) ? hazard : !bus.mem_ack;
    end
  end

  assign bus.stall     = stall_c;
  assign bus.bubble    = stall_c;
  assign bus.stall_cnt = stall_cnt_q;

`ifdef LOAD_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_err_q;
  logic              wait_expired;

  // Counter holds the number of WAIT_MEM cycles already completed.
  assign wait_expired    = (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
  assign bus.timeout_err = timeout_err_q;
`else
  wire unused_timeout_cyc = ^TIMEOUT_CYC;
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      stall_cnt_q <= '0;
`ifdef LOAD_TIMEOUT_EN
      wait_cnt      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      if (stall_c && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
`ifdef LOAD_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (hazard && !bus.flush) begin
            state <= ST_WAIT_MEM;
          end
`ifdef LOAD_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_WAIT_MEM: begin
          // A flushed ID no longer needs the data; the load itself still
          // completes in MEM without our involvement.
          if (bus.flush || bus.mem_ack) begin
            state <= ST_IDLE;
`ifdef LOAD_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (wait_expired) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            timeout_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// tb/tb_load_use_stall_ctrl.sv - self-checking bench for load_use_stall_ctrl
module tb_load_use_stall_ctrl;
  import pipe_pkg::*;

  localparam int TO_CYC = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  load_use_stall_ctrl_if #(.REG_AW(5), .OPCODE_W(6), .CNT_W(16)) bus ();

  load_use_stall_ctrl #(
    .REG_AW(5), .OPCODE_W(6), .CNT_W(16), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string tag;
    logic  s;
    int    cnt;
    logic  te;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [5:0] iop, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ev, input logic [5:0] eop,
                       input logic [4:0] ed, input logic ack, input logic fl);
    bus.id_valid  = iv;
    bus.id_opcode = iop;
    bus.id_rs     = rs;
    bus.id_rt     = rt;
    bus.ex_valid  = ev;
    bus.ex_opcode = eop;
    bus.ex_dest   = ed;
    bus.mem_ack   = ack;
    bus.flush     = fl;
  endtask

  task automatic idle_in();
    drive(1'b0, OPCODE_RTYPE, 5'd0, 5'd0, 1'b0, OPCODE_RTYPE, 5'd0, 1'b0, 1'b0);
  endtask

  // Called at posedge+1 with inputs already driven; pushes the expected
  // outputs for this cycle, checks them at the negedge, returns at posedge+1.
  task automatic cycle(input string tag, input logic s, input logic te);
    exp_t e;
    e.tag = tag;
    e.s   = s;
    e.cnt = exp_cnt;
    e.te  = te;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, "_stall"}, 32'(bus.stall), 32'(e.s));
    check({e.tag, "_bubble"}, 32'(bus.bubble), 32'(e.s));
    check({e.tag, "_cnt"}, 32'(bus.stall_cnt), e.cnt);
    check({e.tag, "_terr"}, 32'(bus.timeout_err), 32'(e.te));
    if (e.s && exp_cnt != 65535) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_cnt = 0;
  endtask

  initial begin
    apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_stall", 32'(bus.stall), 0);
    check("rst_bubble", 32'(bus.bubble), 0);
    check("rst_cnt", 32'(bus.stall_cnt), 0);
    check("rst_terr", 32'(bus.timeout_err), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LW r3 / ADD r4,r3,r5 with zero-wait memory: one stall cycle.
    drive(1, OPCODE_RTYPE, 5'd3, 5'd5, 1, OPCODE_LW, 5'd3, 0, 0);
    cycle("t1_hz", 1, 0);
    drive(1, OPCODE_RTYPE, 5'd3, 5'd5, 0, OPCODE_RTYPE, 5'd0, 1, 0);
    cycle("t1_ack", 0, 0);
    idle_in();
    cycle("t1_after", 0, 0);
    check("t1_total", 32'(bus.stall_cnt), 1);

    // Non-hazards: unused rt, r0 destination, J, invalid stages, non-load EX.
    apply_reset();
    drive(1, OPCODE_ADDI, 5'd0, 5'd3, 1, OPCODE_LW, 5'd3, 0, 0);
    cycle("t2_addi_rt", 0, 0);
    drive(1, OPCODE_RTYPE, 5'd0, 5'd5, 1, OPCODE_LW, 5'd0, 0, 0);
    cycle("t2_r0", 0, 0);
    drive(1, OPCODE_J, 5'd3, 5'd3, 1, OPCODE_LW, 5'd3, 0, 0);
    cycle("t2_j", 0, 0);
    drive(1, OPCODE_ADDI, 5'd3, 5'd0, 0, OPCODE_LW, 5'd3, 0, 0);
    cycle("t2_ex_inv", 0, 0);
    drive(0, OPCODE_RTYPE, 5'd3, 5'd3, 1, OPCODE_LW, 5'd3, 0, 0);
    cycle("t2_id_inv", 0, 0);
    drive(1, OPCODE_RTYPE, 5'd3, 5'd3, 1, OPCODE_SW, 5'd3, 0, 0);
    cycle("t2_ex_sw", 0, 0);
    drive(1, OPCODE_SW, 5'd1, 5'd3, 1, OPCODE_LW, 5'd3, 0, 0);
    cycle("t2_sw_rt", 1, 0);
    drive(1, OPCODE_SW, 5'd1, 5'd3, 0, OPCODE_RTYPE, 5'd0, 1, 0);
    cycle("t2_sw_ack", 0, 0);

    // LW r7 / BEQ r1,r7 with three wait cycles: four stalls.
    apply_reset();
    drive(1, OPCODE_BEQ, 5'd1, 5'd7, 1, OPCODE_LW, 5'd7, 0, 0);
    cycle("t3_hz", 1, 0);
    drive(1, OPCODE_BEQ, 5'd1, 5'd7, 0, OPCODE_RTYPE, 5'd0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("t3_wait", 1, 0);
    bus.mem_ack = 1'b1;
    cycle("t3_ack", 0, 0);
    idle_in();
    cycle("t3_after", 0, 0);
    check("t3_total", 32'(bus.stall_cnt), 4);

    // Flush while waiting: stall drops that cycle and the FSM returns to IDLE.
    apply_reset();
    drive(1, OPCODE_RTYPE, 5'd2, 5'd9, 1, OPCODE_LW, 5'd9, 0, 0);
    cycle("t4_hz", 1, 0);
    drive(1, OPCODE_RTYPE, 5'd2, 5'd9, 0, OPCODE_RTYPE, 5'd0, 0, 1);
    cycle("t4_flush", 0, 0);
    idle_in();
    cycle("t4_idle", 0, 0);
    check("t4_total", 32'(bus.stall_cnt), 1);

    // Memory that never answers.
    apply_reset();
    drive(1, OPCODE_RTYPE, 5'd4, 5'd6, 1, OPCODE_LW, 5'd4, 0, 0);
    cycle("t5_hz", 1, 0);
    idle_in();
`ifdef LOAD_TIMEOUT_EN
    for (int i = 0; i < TO_CYC; i++) cycle("t5_wait", 1, 0);
    cycle("t5_timeout", 0, 1);
    cycle("t5_post", 0, 0);
    check("t5_total", 32'(bus.stall_cnt), TO_CYC + 1);

    // mem_ack in the expiry cycle wins over the timeout.
    apply_reset();
    drive(1, OPCODE_RTYPE, 5'd4, 5'd6, 1, OPCODE_LW, 5'd4, 0, 0);
    cycle("t5b_hz", 1, 0);
    idle_in();
    for (int i = 0; i < TO_CYC - 1; i++) cycle("t5b_wait", 1, 0);
    bus.mem_ack = 1'b1;
    cycle("t5b_ack", 0, 0);
    bus.mem_ack = 1'b0;
    cycle("t5b_post", 0, 0);
`else
    for (int i = 0; i < TO_CYC + 2; i++) cycle("t5_wait", 1, 0);
    bus.mem_ack = 1'b1;
    cycle("t5_ack", 0, 0);
    bus.mem_ack = 1'b0;
    cycle("t5_post", 0, 0);
`endif

    // Reset asserted during WAIT_MEM with the hazard still visible.
    apply_reset();
    drive(1, OPCODE_RTYPE, 5'd3, 5'd5, 1, OPCODE_LW, 5'd3, 0, 0);
    cycle("t6_hz", 1, 0);
    drive(1, OPCODE_RTYPE, 5'd3, 5'd5, 0, OPCODE_RTYPE, 5'd0, 0, 0);
    cycle("t6_wait", 1, 0);
    drive(1, OPCODE_RTYPE, 5'd3, 5'd5, 1, OPCODE_LW, 5'd3, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_stall", 32'(bus.stall), 0);
    check("t6_rst_bubble", 32'(bus.bubble), 0);
    check("t6_rst_cnt", 32'(bus.stall_cnt), 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_cnt = 0;
    idle_in();
    cycle("t6_idle", 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
